// File: rtl/sev_seg_pkg.sv
// Shared constants for the 7-segment readback decoder: active-low segment patterns,
// segment bit positions within seg[6:0] = {A,B,C,D,E,F,G}, and the scan FSM state type.
package sev_seg_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [SEG_W-1:0] PAT_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] PAT_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] PAT_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] PAT_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] PAT_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] PAT_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] PAT_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] PAT_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] PAT_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] PAT_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] PAT_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] PAT_B     = 7'b1100000;
  localparam logic [SEG_W-1:0] PAT_C     = 7'b0110001;
  localparam logic [SEG_W-1:0] PAT_D     = 7'b1000010;
  localparam logic [SEG_W-1:0] PAT_E     = 7'b0110000;
  localparam logic [SEG_W-1:0] PAT_F     = 7'b0111000;
  localparam logic [SEG_W-1:0] PAT_BLANK = 7'b1111111;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_HOLD = 1'b1
  } scan_state_t;

endpackage

// File: rtl/sev_seg_pattern_decode.sv
// Combinational active-low segment pattern -> {value, blank, invalid}.
// Hex letters A..F decode only when SEV_SEG_HEX_DECODE_EN is defined; otherwise they are invalid.
module sev_seg_pattern_decode
  import sev_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [3:0]       value,
  output logic             blank,
  output logic             invalid
);

  always_comb begin
    value   = 4'd0;
    blank   = 1'b0;
    invalid = 1'b0;
    case (seg)
      PAT_0:     value = 4'd0;
      PAT_1:     value = 4'd1;
      PAT_2:     value = 4'd2;
      PAT_3:     value = 4'd3;
      PAT_4:     value = 4'd4;
      PAT_5:     value = 4'd5;
      PAT_6:     value = 4'd6;
      PAT_7:     value = 4'd7;
      PAT_8:     value = 4'd8;
      PAT_9:     value = 4'd9;
      PAT_BLANK: blank = 1'b1;
`ifdef SEV_SEG_HEX_DECODE_EN
      PAT_A:     value = 4'hA;
      PAT_B:     value = 4'hB;
      PAT_C:     value = 4'hC;
      PAT_D:     value = 4'hD;
      PAT_E:     value = 4'hE;
      PAT_F:     value = 4'hF;
`else
      PAT_A, PAT_B, PAT_C, PAT_D, PAT_E, PAT_F: invalid = 1'b1;
`endif
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/sev_seg_scan_decoder.sv
// Recovers digit values from a multiplexed active-low 7-segment bus and offers whole frames
// on a valid/ready handshake. Optional hex letter decode: SEV_SEG_HEX_DECODE_EN.
module sev_seg_scan_decoder
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic                    SegA,
  input  logic                    SegB,
  input  logic                    SegC,
  input  logic                    SegD,
  input  logic                    SegE,
  input  logic                    SegF,
  input  logic                    SegG,
  input  logic [NUM_DIGITS-1:0]   DigitSel,
  output logic [4*NUM_DIGITS-1:0] FrameData,
  output logic [NUM_DIGITS-1:0]   FrameBlank,
  output logic [NUM_DIGITS-1:0]   FrameInvalid,
  output logic                    FrameValid,
  input  logic                    FrameReady,
  output logic                    Overrun
);

  localparam int IN_W  = NUM_DIGITS + SEG_W;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 1);

  logic [SEG_W-1:0]      seg_raw;
  logic [IN_W-1:0]       sync1, sync2, prev;
  logic [NUM_DIGITS-1:0] sel_s, slot_hit;
  logic [SEG_W-1:0]      seg_s;
  logic                  sel_onehot, same, stable_ok, capture;
  logic [CNT_W-1:0]      cnt;

  logic [3:0] dec_value;
  logic       dec_blank, dec_invalid;

  logic [4*NUM_DIGITS-1:0] sh_data, mg_data;
  logic [NUM_DIGITS-1:0]   sh_blank, mg_blank, sh_inv, mg_inv;
  logic [NUM_DIGITS-1:0]   mask, mask_merged;
  logic                    frame_done;

  scan_state_t state, state_nxt;
  logic        shadow_we, load_frame, frame_taken, set_ovr;

  always_comb begin
    seg_raw        = '0;
    seg_raw[SEG_A] = SegA;
    seg_raw[SEG_B] = SegB;
    seg_raw[SEG_C] = SegC;
    seg_raw[SEG_D] = SegD;
    seg_raw[SEG_E] = SegE;
    seg_raw[SEG_F] = SegF;
    seg_raw[SEG_G] = SegG;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {DigitSel, seg_raw};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign sel_s      = sync2[IN_W-1:SEG_W];
  assign seg_s      = sync2[SEG_W-1:0];
  assign slot_hit   = ~sel_s;
  assign sel_onehot = $onehot(slot_hit);
  assign same       = (sync2 == prev);
  assign stable_ok  = same && sel_onehot;
  // Fires on the edge the counter reaches saturation, so once per stable interval.
  assign capture    = stable_ok && (cnt == CNT_PRE);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cnt <= '0;
    end else if (!stable_ok) begin
      cnt <= '0;
    end else if (cnt != CNT_SAT) begin
      cnt <= cnt + 1'b1;
    end
  end

  sev_seg_pattern_decode u_decode (
    .seg     (seg_s),
    .value   (dec_value),
    .blank   (dec_blank),
    .invalid (dec_invalid)
  );

  // Shadow contents with the current capture folded in; feeds both shadow and frame loads.
  always_comb begin
    mg_data  = sh_data;
    mg_blank = sh_blank;
    mg_inv   = sh_inv;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_hit[i]) begin
        mg_data[4*i +: 4] = dec_value;
        mg_blank[i]       = dec_blank;
        mg_inv[i]         = dec_invalid;
      end
    end
  end

  assign mask_merged = mask | slot_hit;
  assign frame_done  = &mask_merged;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= ST_SCAN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SCAN: if (capture && frame_done)      state_nxt = ST_HOLD;
      ST_HOLD: if (FrameValid && FrameReady)   state_nxt = ST_SCAN;
      default:                                 state_nxt = ST_SCAN;
    endcase
  end

  always_comb begin
    shadow_we   = 1'b0;
    load_frame  = 1'b0;
    frame_taken = 1'b0;
    set_ovr     = 1'b0;
    case (state)
      ST_SCAN: begin
        shadow_we  = capture;
        load_frame = capture && frame_done;
      end
      ST_HOLD: begin
        frame_taken = FrameValid && FrameReady;
        set_ovr     = capture;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sh_data      <= '0;
      sh_blank     <= '0;
      sh_inv       <= '0;
      mask         <= '0;
      FrameData    <= '0;
      FrameBlank   <= '0;
      FrameInvalid <= '0;
      FrameValid   <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      if (shadow_we) begin
        sh_data  <= mg_data;
        sh_blank <= mg_blank;
        sh_inv   <= mg_inv;
        mask     <= load_frame ? '0 : mask_merged;
      end
      if (load_frame) begin
        FrameData    <= mg_data;
        FrameBlank   <= mg_blank;
        FrameInvalid <= mg_inv;
        FrameValid   <= 1'b1;
      end
      if (frame_taken) FrameValid <= 1'b0;
      if (set_ovr)     Overrun    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sev_seg_scan_decoder.sv
// Directed + randomized bench for sev_seg_scan_decoder against a frame-level reference model.
module tb_sev_seg_scan_decoder;

  localparam int ND      = 4;
  localparam int SC      = 8;
  localparam int LONG_T  = 20;
  localparam int SHORT_T = 4;

`ifdef SEV_SEG_HEX_DECODE_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          nReset = 1'b0;
  logic [6:0]    seg = 7'h7F;
  logic [ND-1:0] sel = '1;
  logic          FrameReady = 1'b0;
  logic [4*ND-1:0] FrameData;
  logic [ND-1:0]   FrameBlank, FrameInvalid;
  logic            FrameValid, Overrun;

  int errors = 0;
  int checks = 0;

  logic [6:0] pat_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic [3:0]   m_sh_val [ND];
  logic         m_sh_blk [ND];
  logic         m_sh_inv [ND];
  bit           m_mask   [ND];
  logic [4*ND-1:0] m_data;
  logic [ND-1:0]   m_blk, m_inv;
  bit           m_valid, m_ovr;

  always #5 Clock = ~Clock;

  sev_seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .Clock        (Clock),
    .nReset       (nReset),
    .SegA         (seg[6]),
    .SegB         (seg[5]),
    .SegC         (seg[4]),
    .SegD         (seg[3]),
    .SegE         (seg[2]),
    .SegF         (seg[1]),
    .SegG         (seg[0]),
    .DigitSel     (sel),
    .FrameData    (FrameData),
    .FrameBlank   (FrameBlank),
    .FrameInvalid (FrameInvalid),
    .FrameValid   (FrameValid),
    .FrameReady   (FrameReady),
    .Overrun      (Overrun)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_known(input logic [6:0] p);
    bit k = (p == 7'h7F);
    for (int i = 0; i < 16; i++) if (pat_tab[i] == p) k = 1'b1;
    return k;
  endfunction

  task automatic ref_decode(input logic [6:0] p, output logic [3:0] v, output logic b, output logic iv);
    v = 4'd0; b = 1'b0; iv = 1'b1;
    if (p == 7'h7F) begin
      b = 1'b1; iv = 1'b0;
    end else begin
      for (int k = 0; k < 16; k++)
        if (pat_tab[k] == p && (k < 10 || HEX_EN)) begin
          v = k[3:0]; iv = 1'b0;
        end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_sh_val[i] = '0; m_sh_blk[i] = 1'b0; m_sh_inv[i] = 1'b0; m_mask[i] = 1'b0;
    end
    m_data = '0; m_blk = '0; m_inv = '0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_capture(input int d, input logic [6:0] p);
    bit all;
    if (m_valid) begin
      m_ovr = 1'b1;
      return;
    end
    ref_decode(p, m_sh_val[d], m_sh_blk[d], m_sh_inv[d]);
    m_mask[d] = 1'b1;
    all = 1'b1;
    for (int i = 0; i < ND; i++) all &= m_mask[i];
    if (all) begin
      for (int i = 0; i < ND; i++) begin
        m_data[4*i +: 4] = m_sh_val[i];
        m_blk[i] = m_sh_blk[i];
        m_inv[i] = m_sh_inv[i];
        m_mask[i] = 1'b0;
      end
      m_valid = 1'b1;
    end
  endtask

  // Strobe digit d with pattern p for the given time, then a short all-off gap.
  task automatic show(input int d, input logic [6:0] p, input int cycles);
    sel = ~(ND'(1) << d);
    seg = p;
    tick(cycles);
    sel = '1;
    tick(2);
    if (cycles >= LONG_T) model_capture(d, p);
  endtask

  task automatic chk_frame(input string tag);
    chk({tag, ".valid"}, FrameValid, m_valid);
    chk({tag, ".ovr"}, Overrun, m_ovr);
    if (m_valid) begin
      chk({tag, ".data"}, FrameData, m_data);
      chk({tag, ".blank"}, FrameBlank, m_blk);
      chk({tag, ".inv"}, FrameInvalid, m_inv);
    end
  endtask

  task automatic consume(input string tag);
    FrameReady = 1'b1;
    tick(1);
    FrameReady = 1'b0;
    m_valid = 1'b0;
    chk({tag, ".drop"}, FrameValid, 1'b0);
    tick(1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid0"}, FrameValid, 1'b0);
    chk({tag, ".data0"}, FrameData, '0);
    chk({tag, ".blank0"}, FrameBlank, '0);
    chk({tag, ".inv0"}, FrameInvalid, '0);
    chk({tag, ".ovr0"}, Overrun, 1'b0);
  endtask

  initial begin
    int d, kind;
    logic [6:0] p;

    model_reset();
    tick(2);
    chk_zero("reset");
    nReset = 1'b1;
    tick(2);

    // Basic frame 4321
    for (int i = 0; i < ND; i++) show(i, pat_tab[i+1], LONG_T);
    chk_frame("t1");
    chk("t1.lit", FrameData, 16'h4321);
    consume("t1");

    // Segment glitches every 5 cycles on digit 0: never captured
    sel = ~4'b0001;
    for (int k = 0; k < 8; k++) begin
      seg = pat_tab[(k % 2 == 0) ? 8 : 1];
      tick(5);
    end
    sel = '1;
    tick(2);
    for (int i = 1; i < ND; i++) show(i, pat_tab[i+5], LONG_T);
    chk_frame("t2.glitch");
    show(0, pat_tab[9], LONG_T);
    chk_frame("t2.done");
    consume("t2");

    // Blank and invalid patterns
    show(0, pat_tab[5], LONG_T);
    show(1, 7'b1010101, LONG_T);
    show(2, 7'h7F, LONG_T);
    show(3, pat_tab[7], LONG_T);
    chk_frame("t3");
    chk("t3.blank_lit", FrameBlank, 4'b0100);
    chk("t3.inv_lit", FrameInvalid, 4'b0010);
    chk("t3.data_lit", FrameData, 16'h7005);

    // Pending frame not consumed: captures discarded, overrun set
    show(1, pat_tab[3], LONG_T);
    show(2, pat_tab[6], LONG_T);
    chk_frame("t4.hold");
    chk("t4.ovr_lit", Overrun, 1'b1);
    consume("t4");
    for (int i = 0; i < ND; i++) show(ND-1-i, pat_tab[2*i], LONG_T);
    chk_frame("t4.next");
    consume("t4b");

    // Hex letter on digit 0
    show(0, pat_tab[10], LONG_T);
    for (int i = 1; i < ND; i++) show(i, pat_tab[i], LONG_T);
    chk_frame("t5");
    consume("t5");

    // Reset mid-frame
    show(0, pat_tab[4], LONG_T);
    show(1, pat_tab[5], LONG_T);
    nReset = 1'b0;
    tick(1);
    model_reset();
    chk_zero("t6.rst");
    nReset = 1'b1;
    tick(2);
    show(2, pat_tab[8], LONG_T);
    show(3, pat_tab[9], LONG_T);
    chk_frame("t6.partial");
    show(0, pat_tab[1], LONG_T);
    show(1, pat_tab[2], LONG_T);
    chk_frame("t6.full");
    consume("t6");

    // Randomized shows against the model
    for (int n = 0; n < 60; n++) begin
      d    = int'($urandom_range(0, ND-1));
      kind = int'($urandom_range(0, 9));
      if (kind <= 5)      p = pat_tab[$urandom_range(0, 9)];
      else if (kind == 6) p = pat_tab[$urandom_range(10, 15)];
      else if (kind == 7) p = 7'h7F;
      else if (kind == 8) begin
        p = 7'($urandom);
        while (is_known(p)) p = 7'($urandom);
      end else p = pat_tab[$urandom_range(0, 9)];
      show(d, p, (kind == 9) ? SHORT_T : LONG_T);
      chk_frame("rnd");
      if (m_valid && $urandom_range(0, 2) == 0) consume("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
